// File: rtl/arb_pkg.sv
// Shared types and helpers for the eight-requester round-robin arbiter.
// The rotate helper lines the search origin up with bit 0 for a fixed-priority encode.
package arb_pkg;

  localparam int N_REQ = 8;
  localparam int IDX_W = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  // Rotate right by sh, so that bit sh of v lands at position 0.
  function automatic logic [N_REQ-1:0] rotr(input logic [N_REQ-1:0] v,
                                             input logic [IDX_W-1:0] sh);
    logic [2*N_REQ-1:0] dbl;
    dbl  = {v, v} >> sh;
    rotr = dbl[N_REQ-1:0];
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational rotating priority encoder: rotate by ptr, pick the lowest set bit,
// then un-rotate. Bits cleared in mask never win.
module rr_pick
  import arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  input  logic [N_REQ-1:0] mask,
  output logic [IDX_W-1:0] idx,
  output logic             found
);

  logic [N_REQ-1:0] eligible;
  logic [N_REQ-1:0] rotated;
  logic [IDX_W-1:0] enc;

  assign eligible = req & mask;
  assign rotated  = rotr(eligible, ptr);
  assign found    = |eligible;

  // NOTE: every variable written in always_comb gets a default first; a path that
  // leaves one unassigned infers a latch.
  always_comb begin
    enc = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (rotated[i]) enc = IDX_W'(i);
    end
  end

  // The 3-bit add wraps modulo 8, which undoes the rotation.
  assign idx = enc + ptr;

endmodule

// File: rtl/rr_req_arbiter.sv
// Eight-way round-robin arbiter with grant hold and a hold-limit that forces
// rotation when other requesters wait. All outputs are registered.
module rr_req_arbiter
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_valid
);

  localparam int CNT_W = $clog2(MAX_HOLD + 1);
  localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(MAX_HOLD);
  localparam logic [CNT_W-1:0] HOLD_ONE = CNT_W'(1);

  state_t           state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0] hold_q, hold_d;
  logic [N_REQ-1:0] gnt_d;
  logic [IDX_W-1:0] idx_d;
  logic             valid_d;

  logic [IDX_W-1:0] pick_idx;
  logic             pick_found;
  logic             owner_req;
  logic             hold_sat;
  logic             load;
  logic             clear;

  // Masking the current owner excludes it on preemption; on release its request
  // is already low, and in IDLE gnt is zero, so one mask serves every case.
  rr_pick u_pick (
    .req   (req),
    .ptr   (ptr_q),
    .mask  (~gnt),
    .idx   (pick_idx),
    .found (pick_found)
  );

  assign owner_req = |(req & gnt);
  assign hold_sat  = (hold_q >= HOLD_MAX);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      hold_q    <= '0;
      gnt       <= '0;
      gnt_idx   <= '0;
      gnt_valid <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      hold_q    <= hold_d;
      gnt       <= gnt_d;
      gnt_idx   <= idx_d;
      gnt_valid <= valid_d;
    end
  end

  // Next-state: decide whether a new owner is loaded, the grant is cleared, or held.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    hold_d  = hold_q;
    load    = 1'b0;
    clear   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (pick_found) begin
          state_d = GRANT;
          load    = 1'b1;
        end
      end
      GRANT: begin
        if (!owner_req) begin
          if (pick_found) begin
            load = 1'b1;
          end else begin
            state_d = IDLE;
            clear   = 1'b1;
          end
        end else if (hold_sat && pick_found) begin
          load = 1'b1;
        end else if (!hold_sat) begin
          hold_d = hold_q + HOLD_ONE;
        end
      end
      default: begin
        state_d = IDLE;
        clear   = 1'b1;
      end
    endcase
    if (load) begin
      hold_d = HOLD_ONE;
      ptr_d  = pick_idx + IDX_W'(1);
    end
    if (clear) hold_d = '0;
  end

  // Output: next values of the registered grant outputs, kept mutually consistent.
  always_comb begin
    gnt_d   = gnt;
    idx_d   = gnt_idx;
    valid_d = gnt_valid;
    if (load) begin
      gnt_d   = N_REQ'(1) << pick_idx;
      idx_d   = pick_idx;
      valid_d = 1'b1;
    end else if (clear) begin
      gnt_d   = '0;
      idx_d   = '0;
      valid_d = 1'b0;
    end
  end

endmodule

// File: tb/tb_rr_req_arbiter.sv
// Scoreboard bench for rr_req_arbiter: three instances (MAX_HOLD 16, 4, 1) share
// req and rst_n; each queued expectation names the instance it applies to.
module tb_rr_req_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] req = 8'h00;

  logic [7:0] gnt_w   [3];
  logic [2:0] idx_w   [3];
  logic       valid_w [3];

  typedef struct {
    int         sel;
    int         id;
    logic [7:0] gnt;
    logic [2:0] idx;
    logic       valid;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   step_id = 0;

  always #5 clk = ~clk;

  rr_req_arbiter #(.MAX_HOLD(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .req(req),
    .gnt(gnt_w[0]), .gnt_idx(idx_w[0]), .gnt_valid(valid_w[0])
  );
  rr_req_arbiter #(.MAX_HOLD(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .req(req),
    .gnt(gnt_w[1]), .gnt_idx(idx_w[1]), .gnt_valid(valid_w[1])
  );
  rr_req_arbiter #(.MAX_HOLD(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .req(req),
    .gnt(gnt_w[2]), .gnt_idx(idx_w[2]), .gnt_valid(valid_w[2])
  );

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive req at the falling edge and queue the outputs expected after the next rising edge.
  task automatic step(input int sel, input logic [7:0] r, input logic [7:0] eg,
                      input logic [2:0] ei);
    exp_t e;
    @(negedge clk);
    req     = r;
    e.sel   = sel;
    e.id    = step_id;
    e.gnt   = eg;
    e.idx   = ei;
    e.valid = (eg != 8'h00);
    q.push_back(e);
    step_id++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req   = 8'h00;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Monitor: samples 2 time units after each rising edge and scores one entry.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (q.size() > 0) begin
        e = q.pop_front();
        check($sformatf("gnt[dut%0d step%0d]", e.sel, e.id), gnt_w[e.sel], e.gnt);
        check($sformatf("idx[dut%0d step%0d]", e.sel, e.id), {5'b0, idx_w[e.sel]}, {5'b0, e.idx});
        check($sformatf("valid[dut%0d step%0d]", e.sel, e.id), {7'b0, valid_w[e.sel]},
              {7'b0, e.valid});
      end
    end
  end

  initial begin
    logic [7:0] one_hot;

    // Idle after reset.
    do_reset();
    for (int i = 0; i < 5; i++) step(0, 8'h00, 8'h00, 3'd0);

    // Grant to 3 from {3,5}, then seamless handover to 5 on release.
    step(0, 8'h28, 8'h08, 3'd3);
    step(0, 8'h20, 8'h20, 3'd5);
    step(0, 8'h20, 8'h20, 3'd5);
    step(0, 8'h00, 8'h00, 3'd0);

    // MAX_HOLD=4, two contenders: 0 x4, 1 x4, 0 x4.
    do_reset();
    for (int i = 0; i < 4; i++) step(1, 8'h03, 8'h01, 3'd0);
    for (int i = 0; i < 4; i++) step(1, 8'h03, 8'h02, 3'd1);
    for (int i = 0; i < 4; i++) step(1, 8'h03, 8'h01, 3'd0);

    // MAX_HOLD=4, lone requester keeps the grant; a newcomer preempts at once.
    step(1, 8'h00, 8'h00, 3'd0);
    for (int i = 0; i < 10; i++) step(1, 8'h04, 8'h04, 3'd2);
    step(1, 8'h44, 8'h40, 3'd6);

    // MAX_HOLD=1, all requesting: rotate 0..7 and wrap to 0.
    do_reset();
    for (int i = 0; i < 9; i++) begin
      one_hot = 8'h01 << (i % 8);
      step(2, 8'hFF, one_hot, 3'(i % 8));
    end

    // Asynchronous reset mid-grant, then ptr must search from 0 again.
    do_reset();
    step(0, 8'h20, 8'h20, 3'd5);
    step(0, 8'h20, 8'h20, 3'd5);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_rst gnt", gnt_w[0], 8'h00);
    check("async_rst idx", {5'b0, idx_w[0]}, 8'h00);
    check("async_rst valid", {7'b0, valid_w[0]}, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    begin
      exp_t e;
      req     = 8'hA0;
      e.sel   = 0;
      e.id    = step_id;
      e.gnt   = 8'h20;
      e.idx   = 3'd5;
      e.valid = 1'b1;
      q.push_back(e);
      step_id++;
    end

    // Drain the scoreboard with a bounded wait.
    for (int k = 0; k < 20 && q.size() > 0; k++) @(posedge clk);
    #3;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
